// File: rtl/ym3438_pkg.sv
// rtl/ym3438_pkg.sv - shared constants, slot decoding and output saturation for the YM3438 mixer
package ym3438_pkg;
    localparam int SLOTS    = 24;
    localparam int CHANNELS = 6;
    localparam int OP_W     = 14;
    localparam int OUT_W    = 9;
    localparam int SAT_MAX  = 255;
    localparam int SAT_MIN  = -256;
    localparam int SLOT_W   = 5;
    localparam int CH_W     = 3;

    // Slot groups in frame order: op1, op3, op2, op4.
    typedef enum logic [1:0] {
        GRP_OP1 = 2'd0,
        GRP_OP3 = 2'd1,
        GRP_OP2 = 2'd2,
        GRP_OP4 = 2'd3
    } grp_e;

    function automatic logic [CH_W-1:0] slot_ch(input logic [SLOT_W-1:0] s);
        logic [SLOT_W-1:0] r;
        r = s % SLOT_W'(CHANNELS);
        return r[CH_W-1:0];
    endfunction

    function automatic grp_e slot_grp(input logic [SLOT_W-1:0] s);
        logic [SLOT_W-1:0] q;
        q = s / SLOT_W'(CHANNELS);
        return grp_e'(q[1:0]);
    endfunction

    function automatic logic signed [OUT_W-1:0] sat9(input logic signed [31:0] v);
        logic signed [31:0] r;
        if (v > SAT_MAX)
            r = SAT_MAX;
        else if (v < SAT_MIN)
            r = SAT_MIN;
        else
            r = v;
        return r[OUT_W-1:0];
    endfunction
endpackage

// File: rtl/ym3438_ch_acc_sr.sv
// rtl/ym3438_ch_acc_sr.sv - per-channel accumulator register file, read and written on the slot enable
module ym3438_ch_acc_sr
    import ym3438_pkg::*;
#(
    parameter int ACC_W = 16
)
(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic [CH_W-1:0]         i_ch,
    input  logic signed [ACC_W-1:0] i_wr_data,
    output logic signed [ACC_W-1:0] o_rd_data
);
    logic signed [ACC_W-1:0] r_acc [CHANNELS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < CHANNELS; i++)
                r_acc[i] <= '0;
        end else if (i_en) begin
            r_acc[i_ch] <= i_wr_data;
        end
    end

    assign o_rd_data = r_acc[i_ch];
endmodule

// File: rtl/ym3438_ch_accum.sv
// rtl/ym3438_ch_accum.sv - channel accumulator and time-multiplexed MOL/MOR output mixer
module ym3438_ch_accum
    import ym3438_pkg::*;
#(
    parameter int ACC_W   = 16,
    parameter int OUT_SHR = 5
)
(
    input  logic                    MCLK,
    input  logic                    IC,
    input  logic                    c1,
    input  logic                    c2,
    input  logic                    sync,
    input  logic signed [OP_W-1:0]  op_output,
    input  logic                    alg_out,
    input  logic                    pan_l,
    input  logic                    pan_r,
    input  logic                    dac_en,
    input  logic [7:0]              dac_data,
    output logic signed [OUT_W-1:0] MOL,
    output logic signed [OUT_W-1:0] MOR,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_valid
);
    logic [SLOT_W-1:0]       r_cnt;
    logic [SLOT_W-1:0]       w_slot;
    logic [SLOT_W-1:0]       w_slot_next;
    logic [CH_W-1:0]         w_ch;
    grp_e                    w_grp;
    logic signed [ACC_W-1:0] w_acc_rd;
    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_acc_wr;
    logic signed [ACC_W-1:0] w_shr;
    logic signed [31:0]      w_shr_ext;
    logic signed [OUT_W-1:0] w_sat;
    logic signed [OUT_W-1:0] w_val;
    logic signed [OUT_W-1:0] r_pend_l;
    logic signed [OUT_W-1:0] r_pend_r;
    logic [CH_W-1:0]         r_pend_ch;
    logic                    r_pend_v;
    logic signed [OUT_W-1:0] r_mol;
    logic signed [OUT_W-1:0] r_mor;
    logic [CH_W-1:0]         r_out_ch;
    logic                    r_out_valid;

    // sync forces slot 0 on the same c1, so a mid-frame resync takes effect immediately.
    assign w_slot      = sync ? '0 : r_cnt;
    assign w_slot_next = (w_slot == SLOT_W'(SLOTS - 1)) ? '0 : w_slot + SLOT_W'(1);
    assign w_ch        = slot_ch(w_slot);
    assign w_grp       = slot_grp(w_slot);

    assign w_term    = alg_out ? {{(ACC_W-OP_W){op_output[OP_W-1]}}, op_output} : '0;
    assign w_sum     = w_acc_rd + w_term;
    assign w_acc_wr  = (w_grp == GRP_OP1) ? w_term : w_sum;
    assign w_shr     = w_sum >>> OUT_SHR;
    assign w_shr_ext = {{(32-ACC_W){w_shr[ACC_W-1]}}, w_shr};
    assign w_sat     = sat9(w_shr_ext);
    assign w_val     = (dac_en && w_ch == CH_W'(CHANNELS - 1))
                     ? {~dac_data[7], dac_data[6:0], 1'b0} : w_sat;

    ym3438_ch_acc_sr #(.ACC_W(ACC_W)) u_acc (
        .i_clk     (MCLK),
        .i_rst_n   (IC),
        .i_en      (c1),
        .i_ch      (w_ch),
        .i_wr_data (w_acc_wr),
        .o_rd_data (w_acc_rd)
    );

    // The c2 transfer reads pend before the c1 latch below can replace it on the same edge.
    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            r_cnt       <= '0;
            r_pend_l    <= '0;
            r_pend_r    <= '0;
            r_pend_ch   <= '0;
            r_pend_v    <= 1'b0;
            r_mol       <= '0;
            r_mor       <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (c2 && r_pend_v) begin
                r_mol       <= r_pend_l;
                r_mor       <= r_pend_r;
                r_out_ch    <= r_pend_ch;
                r_out_valid <= 1'b1;
                r_pend_v    <= 1'b0;
            end
            if (c1) begin
                r_cnt <= w_slot_next;
                if (w_grp == GRP_OP4) begin
                    r_pend_l  <= pan_l ? w_val : '0;
                    r_pend_r  <= pan_r ? w_val : '0;
                    r_pend_ch <= w_ch;
                    r_pend_v  <= 1'b1;
                end
            end
        end
    end

    assign MOL       = r_mol;
    assign MOR       = r_mor;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
endmodule
